txtnt_bus_master: RTL and testbench

- Bus initiator for the TxtNt text/PWM peripheral bus (addr/data/OE/WR/OK).
- Drives transactions into the text module's bus port, replacing the idle tie-off currently used at top level.
- Converts a simple valid/ready command stream into single bus read or write cycles, and returns a response.
- Used by the boot/console logic to write character cells and read back status.

---
 rtl/txtnt_bus_master.sv | 163 ++++++++++++++++
 tb/tb_txtnt_bus_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/txtnt_bus_master.sv
// txtnt_bus_master: turns a valid/ready command stream into single read or
// write cycles on the TxtNt addr/data/OE/WR/OK bus and returns one response
// per accepted command. A bounded wait on busOK turns a missing or stuck
// acknowledge into a timeout instead of a hang.
module txtnt_bus_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdWrite,
  input  logic [ADDR_W-1:0] cmdAddr,
  input  logic [DATA_W-1:0] cmdData,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  output logic              rspErr,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busDataOut,
  input  logic [DATA_W-1:0] busDataIn,
  output logic              busOE,
  output logic              busWR,
  input  logic              busOK
);

  // A zero TIMEOUT still gets a one-bit counter so the declarations stay legal.
  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]  bus_dout_q, bus_dout_d;
  logic               bus_oe_q, bus_oe_d;
  logic               bus_wr_q, bus_wr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic               wait_expired;
  logic [CNT_W-1:0]   cnt_inc;

  // The same counter bounds both the acknowledge wait and the release wait.
  assign wait_expired = TO_EN && (cnt_q == TO_LAST);
  // Saturating increment: a long wait with the timeout disabled never wraps.
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // State register and all registered outputs; reset drops strobes at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
      bus_oe_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
      bus_oe_q    <= bus_oe_d;
      bus_wr_q    <= bus_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and wait counter: acknowledge beats timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cmdValid) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (busOK || wait_expired) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RELEASE: begin
        if (!busOK || wait_expired) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the next cycle: launch a bus cycle on accept, close it
  // and emit a single response on acknowledge or timeout.
  always_comb begin
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = bus_dout_q;
    bus_oe_d    = bus_oe_q;
    bus_wr_d    = bus_wr_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmdValid) begin
          bus_addr_d = cmdAddr;
          bus_wr_d   = cmdWrite;
          bus_oe_d   = !cmdWrite;
          bus_dout_d = cmdWrite ? cmdData : '0;
        end
      end
      S_REQ: begin
        if (busOK || wait_expired) begin
          bus_addr_d  = '0;
          bus_dout_d  = '0;
          bus_oe_d    = 1'b0;
          bus_wr_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !busOK;
          rsp_data_d  = (busOK && bus_oe_q) ? busDataIn : '0;
        end
      end
      default: begin
        bus_oe_d = 1'b0;
        bus_wr_d = 1'b0;
      end
    endcase
  end

  assign cmdReady   = (state_q == S_IDLE);
  assign busAddr    = bus_addr_q;
  assign busDataOut = bus_dout_q;
  assign busOE      = bus_oe_q;
  assign busWR      = bus_wr_q;
  assign rspValid   = rsp_valid_q;
  assign rspData    = rsp_data_q;
  assign rspErr     = rsp_err_q;

endmodule

// File: tb/tb_txtnt_bus_master.sv
// tb_txtnt_bus_master: directed stimulus for txtnt_bus_master with a
// response scoreboard. Stimulus pushes the expected response; a monitor pops
// and compares whenever rspValid is seen.
module tb_txtnt_bus_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic        cmdWrite = 1'b0;
  logic [31:0] cmdAddr = '0;
  logic [31:0] cmdData = '0;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;
  logic [31:0] busAddr;
  logic [31:0] busDataOut;
  logic [31:0] busDataIn = '0;
  logic        busOE;
  logic        busWR;
  logic        busOK = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rsp_count = 0;

  txtnt_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
    .cmdAddr(cmdAddr), .cmdData(cmdData),
    .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
    .busAddr(busAddr), .busDataOut(busDataOut), .busDataIn(busDataIn),
    .busOE(busOE), .busWR(busWR), .busOK(busOK)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    exp_q.push_back(r);
  endtask

  // Issue one command from IDLE; returns in the first REQ cycle.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmdValid = 1'b1;
    cmdWrite = wr;
    cmdAddr  = a;
    cmdData  = d;
    tick();
    cmdValid = 1'b0;
  endtask

  // Monitor: strobe exclusivity every cycle, scoreboard on each response.
  always @(negedge clock) begin
    rsp_t e;
    check("strobe_exclusive", {63'd0, busOE & busWR}, 64'd0);
    if (rspValid) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data=0x%0h err=%0b, required no response", rspData, rspErr);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", {32'd0, rspData}, {32'd0, e.data});
        check("rsp_err", {63'd0, rspErr}, {63'd0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int rc;

    // Reset state
    repeat (2) tick();
    check("rst_cmdReady", {63'd0, cmdReady}, 64'd1);
    check("rst_busOE", {63'd0, busOE}, 64'd0);
    check("rst_busWR", {63'd0, busWR}, 64'd0);
    check("rst_busAddr", {32'd0, busAddr}, 64'd0);
    check("rst_rspValid", {63'd0, rspValid}, 64'd0);
    check("rst_rspData", {32'd0, rspData}, 64'd0);
    reset = 1'b1;
    tick();

    // Write, acknowledge on the 3rd REQ cycle for one cycle
    issue(1'b1, 32'h0000_8000, 32'h0000_0041);
    check("wr_c1_busWR", {63'd0, busWR}, 64'd1);
    check("wr_c1_busOE", {63'd0, busOE}, 64'd0);
    check("wr_c1_busAddr", {32'd0, busAddr}, 64'h8000);
    check("wr_c1_busDataOut", {32'd0, busDataOut}, 64'h41);
    check("wr_c1_cmdReady", {63'd0, cmdReady}, 64'd0);
    tick();
    check("wr_c2_busWR", {63'd0, busWR}, 64'd1);
    tick();
    check("wr_c3_busWR", {63'd0, busWR}, 64'd1);
    check("wr_c3_busAddr", {32'd0, busAddr}, 64'h8000);
    busOK = 1'b1;
    expect_rsp(32'd0, 1'b0);
    tick();
    busOK = 1'b0;
    check("wr_rel_busWR", {63'd0, busWR}, 64'd0);
    check("wr_rel_busAddr", {32'd0, busAddr}, 64'd0);
    check("wr_rel_cmdReady", {63'd0, cmdReady}, 64'd0);
    tick();
    check("wr_idle_cmdReady", {63'd0, cmdReady}, 64'd1);

    // Read acknowledged in the first REQ cycle
    issue(1'b0, 32'h0000_0010, 32'h1234_5678);
    check("rd_busOE", {63'd0, busOE}, 64'd1);
    check("rd_busWR", {63'd0, busWR}, 64'd0);
    check("rd_busAddr", {32'd0, busAddr}, 64'h10);
    check("rd_busDataOut", {32'd0, busDataOut}, 64'd0);
    busOK = 1'b1;
    busDataIn = 32'hDEAD_BEEF;
    expect_rsp(32'hDEAD_BEEF, 1'b0);
    tick();
    busOK = 1'b0;
    busDataIn = '0;
    check("rd_rel_busOE", {63'd0, busOE}, 64'd0);
    tick();
    check("rd_idle_cmdReady", {63'd0, cmdReady}, 64'd1);

    // Timeout: busOK never asserted, TIMEOUT=16
    expect_rsp(32'd0, 1'b1);
    issue(1'b0, 32'h0000_0020, 32'd0);
    n = 0;
    while (busOE && n < 40) begin
      n++;
      tick();
    end
    check("to_oe_cycles", 64'(n), 64'd16);
    check("to_rel_cmdReady", {63'd0, cmdReady}, 64'd0);
    tick();
    check("to_idle_cmdReady", {63'd0, cmdReady}, 64'd1);

    // Stuck acknowledge: busOK held for 5 cycles after the ack
    rc = rsp_count;
    issue(1'b1, 32'h0000_0030, 32'h0000_0055);
    busOK = 1'b1;
    expect_rsp(32'd0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stuck_cmdReady", {63'd0, cmdReady}, 64'd0);
      tick();
    end
    busOK = 1'b0;
    check("stuck_last_cmdReady", {63'd0, cmdReady}, 64'd0);
    tick();
    check("stuck_idle_cmdReady", {63'd0, cmdReady}, 64'd1);
    check("stuck_rsp_count", 64'(rsp_count - rc), 64'd1);

    // Back-to-back with cmdValid held high
    cmdValid = 1'b1;
    cmdWrite = 1'b1;
    cmdAddr  = 32'h0000_0040;
    cmdData  = 32'h0000_0011;
    tick();
    check("b2b_1_busWR", {63'd0, busWR}, 64'd1);
    check("b2b_1_busAddr", {32'd0, busAddr}, 64'h40);
    cmdWrite = 1'b0;
    cmdAddr  = 32'h0000_0044;
    busOK = 1'b1;
    expect_rsp(32'd0, 1'b0);
    tick();
    busOK = 1'b0;
    check("b2b_rel_busWR", {63'd0, busWR}, 64'd0);
    check("b2b_rel_busOE", {63'd0, busOE}, 64'd0);
    check("b2b_rel_cmdReady", {63'd0, cmdReady}, 64'd0);
    tick();
    check("b2b_gap_cmdReady", {63'd0, cmdReady}, 64'd1);
    check("b2b_gap_busOE", {63'd0, busOE}, 64'd0);
    tick();
    cmdValid = 1'b0;
    check("b2b_2_busOE", {63'd0, busOE}, 64'd1);
    check("b2b_2_busAddr", {32'd0, busAddr}, 64'h44);
    busOK = 1'b1;
    busDataIn = 32'hCAFE_F00D;
    expect_rsp(32'hCAFE_F00D, 1'b0);
    tick();
    busOK = 1'b0;
    busDataIn = '0;
    tick();
    check("b2b_end_cmdReady", {63'd0, cmdReady}, 64'd1);

    // Reset in the middle of a read
    issue(1'b0, 32'h0000_0050, 32'd0);
    tick();
    check("rstmid_busOE_before", {63'd0, busOE}, 64'd1);
    rc = rsp_count;
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_busOE_async", {63'd0, busOE}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    check("rstmid_cmdReady", {63'd0, cmdReady}, 64'd1);
    check("rstmid_rspData", {32'd0, rspData}, 64'd0);
    check("rstmid_no_rsp", 64'(rsp_count - rc), 64'd0);
    tick();
    issue(1'b1, 32'h0000_0060, 32'h0000_0077);
    check("post_rst_busWR", {63'd0, busWR}, 64'd1);
    check("post_rst_busDataOut", {32'd0, busDataOut}, 64'h77);
    busOK = 1'b1;
    expect_rsp(32'd0, 1'b0);
    tick();
    busOK = 1'b0;
    tick();
    check("post_rst_cmdReady", {63'd0, cmdReady}, 64'd1);

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
